// File: rtl/poker_pkg.sv
// rtl/poker_pkg.sv - shared encodings and width helper for the hand/round sequencer
package poker_pkg;

  typedef enum logic [1:0] {
    ST_PLAYING = 2'd0,
    ST_CASHOUT = 2'd1,
    ST_LOADING = 2'd2
  } state_t;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/next_live_seat.sv
// rtl/next_live_seat.sv - next live seat above the current one, else lowest live seat with wrap
module next_live_seat
  import poker_pkg::*;
#(
  parameter int N = 2,
  localparam int W = cw(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] seat,
  output logic [W-1:0] next_seat,
  output logic         wrap
);

  logic [W-1:0] up_seat;
  logic [W-1:0] low_seat;
  logic         found;

  // Descending scan so the last hit is the lowest qualifying seat.
  always_comb begin
    up_seat  = '0;
    low_seat = '0;
    found    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) low_seat = W'(i);
      if (mask[i] && (i > int'(seat))) begin
        up_seat = W'(i);
        found   = 1'b1;
      end
    end
    wrap      = !found;
    next_seat = found ? up_seat : low_seat;
  end

endmodule

// File: rtl/poker_round_seq.sv
// rtl/poker_round_seq.sv - hand/round sequencer: load delay, turn rotation, folding, tally and cashout
module poker_round_seq
  import poker_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int N_ROUNDS    = 5,
  parameter int LOAD_CYCLES = 53
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         advance,
  input  logic [N_PLAYERS-1:0]         fold,
  input  logic                         cashout_req,
  output logic [1:0]                   state,
  output logic [$clog2(N_ROUNDS)-1:0]  round,
  output logic [$clog2(N_PLAYERS)-1:0] active_player,
  output logic [N_PLAYERS-1:0]         live_mask,
  output logic                         round_start,
  output logic                         draw_req,
  output logic                         hand_done
);

  localparam int RW = $clog2(N_ROUNDS);
  localparam int AW = $clog2(N_PLAYERS);
  localparam int CW = cw(LOAD_CYCLES);
  localparam logic [RW-1:0] TALLY = RW'(N_ROUNDS - 1);

  state_t              st_q, st_n;
  logic [RW-1:0]       round_n, round_inc;
  logic [AW-1:0]       ap_n;
  logic [N_PLAYERS-1:0] mask_n, fold_mask;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic                rs_n, dr_n, hd_n, restart, fold_ok;
  logic [AW-1:0]       adv_next, fold_next;
  logic                adv_wrap, fold_wrap;

  assign state     = st_q;
  assign round_inc = round + 1'b1;
  assign fold_mask = live_mask & ~(N_PLAYERS'(1) << active_player);
  // The last live player can never fold, so the mask never empties.
  assign fold_ok   = fold[active_player] && ($countones(live_mask) > 1);

  next_live_seat #(.N(N_PLAYERS)) u_adv_seat (
    .mask(live_mask), .seat(active_player), .next_seat(adv_next), .wrap(adv_wrap)
  );

  next_live_seat #(.N(N_PLAYERS)) u_fold_seat (
    .mask(fold_mask), .seat(active_player), .next_seat(fold_next), .wrap(fold_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q          <= ST_LOADING;
      round         <= '0;
      active_player <= '0;
      live_mask     <= '1;
      cnt_q         <= '0;
      round_start   <= 1'b0;
      draw_req      <= 1'b0;
      hand_done     <= 1'b0;
    end else begin
      st_q          <= st_n;
      round         <= round_n;
      active_player <= ap_n;
      live_mask     <= mask_n;
      cnt_q         <= cnt_n;
      round_start   <= rs_n;
      draw_req      <= dr_n;
      hand_done     <= hd_n;
    end
  end

  always_comb begin
    st_n    = st_q;
    round_n = round;
    ap_n    = active_player;
    mask_n  = live_mask;
    cnt_n   = cnt_q;
    rs_n    = 1'b0;
    dr_n    = 1'b0;
    hd_n    = 1'b0;
    restart = 1'b0;
    unique case (st_q)
      ST_LOADING: begin
        if (cnt_q == CW'(LOAD_CYCLES - 1)) begin
          st_n  = ST_PLAYING;
          cnt_n = '0;
          rs_n  = 1'b1;
          dr_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_PLAYING: begin
        if (round == TALLY) begin
          if (advance) begin
            if (cashout_req) st_n = ST_CASHOUT;
            else             restart = 1'b1;
          end
        end else if (fold_ok) begin
          // A fold coincident with advance is a single turn step.
          mask_n = fold_mask;
          ap_n   = fold_next;
          if ($countones(fold_mask) == 1) begin
            round_n = TALLY;
            rs_n    = 1'b1;
          end else if (fold_wrap) begin
            round_n = round_inc;
            rs_n    = 1'b1;
            dr_n    = (round_inc != TALLY);
          end
        end else if (advance) begin
          ap_n = adv_next;
          if (adv_wrap) begin
            round_n = round_inc;
            rs_n    = 1'b1;
            dr_n    = (round_inc != TALLY);
          end
        end
      end
      ST_CASHOUT: begin
        if (!cashout_req) restart = 1'b1;
      end
      default: st_n = ST_LOADING;
    endcase
    if (restart) begin
      st_n    = ST_PLAYING;
      round_n = '0;
      ap_n    = '0;
      mask_n  = '1;
      rs_n    = 1'b1;
      dr_n    = 1'b1;
      hd_n    = 1'b1;
    end
  end

endmodule

// File: tb/tb_poker_round_seq.sv
// tb/tb_poker_round_seq.sv - scoreboard bench for poker_round_seq with a seat-walking reference model
module tb_poker_round_seq;

  localparam int NP = 3;
  localparam int NR = 5;
  localparam int LC = 53;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          advance = 1'b0;
  logic [NP-1:0] fold = '0;
  logic          cashout_req = 1'b0;
  logic [1:0]    state;
  logic [2:0]    round;
  logic [1:0]    active_player;
  logic [NP-1:0] live_mask;
  logic          round_start, draw_req, hand_done;

  int n_cmp = 0;
  int n_err = 0;

  int            m_st, m_round, m_ap, m_cnt;
  logic [NP-1:0] m_mask;
  bit            m_rs, m_dr, m_hd;
  logic [13:0]   sb[$];

  poker_round_seq #(.N_PLAYERS(NP), .N_ROUNDS(NR), .LOAD_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .advance(advance), .fold(fold), .cashout_req(cashout_req),
    .state(state), .round(round), .active_player(active_player), .live_mask(live_mask),
    .round_start(round_start), .draw_req(draw_req), .hand_done(hand_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 2; m_round = 0; m_ap = 0; m_mask = '1; m_cnt = 0;
    m_rs = 0; m_dr = 0; m_hd = 0;
  endtask

  task automatic model_step(input bit a, input logic [NP-1:0] f, input bit c);
    int            nxt;
    bit            wrapped, restart, do_fold;
    logic [NP-1:0] msk;
    restart = 0;
    m_rs = 0; m_dr = 0; m_hd = 0;
    case (m_st)
      2: begin
        if (m_cnt == LC - 1) begin
          m_st = 0; m_cnt = 0; m_rs = 1; m_dr = 1;
        end else m_cnt++;
      end
      0: begin
        if (m_round == NR - 1) begin
          if (a) begin
            if (c) m_st = 1;
            else   restart = 1;
          end
        end else begin
          do_fold = f[m_ap] && ($countones(m_mask) > 1);
          if (do_fold || a) begin
            msk = m_mask;
            if (do_fold) msk[m_ap] = 1'b0;
            nxt = m_ap; wrapped = 0;
            do begin
              nxt = (nxt + 1) % NP;
              if (nxt == 0) wrapped = 1;
            end while (!msk[nxt]);
            m_ap = nxt; m_mask = msk;
            if ($countones(msk) == 1) begin
              m_round = NR - 1; m_rs = 1;
            end else if (wrapped) begin
              m_round++; m_rs = 1; m_dr = (m_round != NR - 1);
            end
          end
        end
      end
      1: if (!c) restart = 1;
      default: ;
    endcase
    if (restart) begin
      m_st = 0; m_round = 0; m_ap = 0; m_mask = '1;
      m_rs = 1; m_dr = 1; m_hd = 1;
    end
  endtask

  function automatic logic [13:0] model_vec();
    return {2'(m_st), 3'(m_round), 2'(m_ap), m_mask, m_rs, m_dr, m_hd};
  endfunction

  task automatic cyc(input bit a, input logic [NP-1:0] f, input bit c);
    logic [13:0] got, exp;
    advance = a; fold = f; cashout_req = c;
    model_step(a, f, c);
    sb.push_back(model_vec());
    @(posedge clk); #1;
    got = {state, round, active_player, live_mask, round_start, draw_req, hand_done};
    if (sb.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
    else begin
      exp = sb.pop_front();
      chk("cycle", 32'(got), 32'(exp));
    end
  endtask

  task automatic rand_cyc();
    logic [NP-1:0] f;
    f = '0;
    if ($urandom_range(0, 2) == 0) f = NP'(1) << $urandom_range(0, NP - 1);
    if ($urandom_range(0, 7) == 0) cashout_req = ~cashout_req;
    cyc(1'($urandom_range(0, 1)), f, cashout_req);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd2);
    chk({tag, "_round"}, 32'(round), 32'd0);
    chk({tag, "_player"}, 32'(active_player), 32'd0);
    chk({tag, "_mask"}, 32'(live_mask), 32'h7);
    chk({tag, "_pulses"}, 32'({round_start, draw_req, hand_done}), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");

    #3 rst = 1'b1;
    for (int i = 0; i < LC - 1; i++) rand_cyc();
    chk("load_pending", 32'(state), 32'd2);
    cyc(0, '0, 0);
    chk("load_state", 32'(state), 32'd0);
    chk("load_pulses", 32'({round_start, draw_req}), 32'b11);

    for (int i = 0; i < 4 * NP; i++) cyc(1, '0, 0);
    chk("hand_round", 32'(round), 32'(NR - 1));
    chk("hand_tally_nodraw", 32'({round_start, draw_req}), 32'b10);
    cyc(1, '0, 0);
    chk("hand_restart", 32'({round, hand_done}), 32'b0001);

    cyc(0, 3'b001, 0);
    cyc(0, 3'b010, 0);
    chk("fold_mask", 32'(live_mask), 32'b100);
    chk("fold_round", 32'(round), 32'(NR - 1));
    chk("fold_round_start", 32'(round_start), 32'd1);
    cyc(0, 3'b100, 0);
    chk("tally_fold_ignored", 32'(live_mask), 32'b100);

    cyc(1, '0, 1);
    chk("cashout_state", 32'(state), 32'd1);
    cyc(1, '0, 1);
    cyc(1, 3'b100, 1);
    chk("cashout_hold", 32'({state, round, live_mask}), {24'd0, 2'd1, 3'(NR - 1), 3'b100});
    cyc(0, '0, 0);
    chk("cashout_exit", 32'({state, round, hand_done}), 32'd1);

    cyc(0, 3'b010, 0);
    chk("nonactive_fold", 32'({active_player, live_mask}), {27'd0, 2'd0, 3'b111});
    cyc(1, 3'b001, 0);
    chk("simul_step", 32'({active_player, live_mask}), {27'd0, 2'd1, 3'b110});

    repeat (4) cyc(1, '0, 0);
    chk("mid_round", 32'(round), 32'd2);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async_reset");
    model_reset();
    #2 rst = 1'b1;
    cashout_req = 1'b0;

    repeat (LC + 400) rand_cyc();
    cyc(0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
